// File: rtl/hilo_div.sv
// hilo_div: multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU.
// Produces {remainder, quotient} 33 cycles after a request is accepted.
// Optional feature macro: HILO_DIV_SIGNED_EN. When it is defined, signed_div_i
// selects signed division. When it is undefined, every request is unsigned.
module hilo_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    localparam logic [1:0] DivFree   = 2'd0;
    localparam logic [1:0] DivByZero = 2'd1;
    localparam logic [1:0] DivOn     = 2'd2;
    localparam logic [1:0] DivEnd    = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    // Working register: {rem[32:0], quo[31:0]}
    logic [64:0] work_q, work_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [31:0] mag1, mag2;
    logic [32:0] trial;
    logic [31:0] quo_fin, rem_fin;

    // rem[32] is always zero after an iteration, so it never reaches the result
    logic        unused_rem_msb;
    assign unused_rem_msb = work_q[64];

    // Shift in the next dividend bit and try to subtract the divisor
    assign trial = work_q[63:31] - {1'b0, dvsr_q};

`ifdef HILO_DIV_SIGNED_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;
    logic neg1, neg2;

    assign neg1    = signed_div_i & opdata1_i[31];
    assign neg2    = signed_div_i & opdata2_i[31];
    assign mag1    = neg1 ? -opdata1_i : opdata1_i;
    assign mag2    = neg2 ? -opdata2_i : opdata2_i;
    assign quo_fin = qneg_q ? -work_q[31:0] : work_q[31:0];
    assign rem_fin = rneg_q ? -work_q[63:32] : work_q[63:32];
`else
    logic unused_signed_div;
    assign unused_signed_div = signed_div_i;
    assign mag1    = opdata1_i;
    assign mag2    = opdata2_i;
    assign quo_fin = work_q[31:0];
    assign rem_fin = work_q[63:32];
`endif

    // Next-state logic for the divider FSM and datapath
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        dvsr_d   = dvsr_q;
        result_d = result_q;
        ready_d  = ready_q;
`ifdef HILO_DIV_SIGNED_EN
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
`endif
        case (state_q)
            DivFree: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == 32'd0) begin
                        state_d = DivByZero;
                    end else begin
                        state_d = DivOn;
                        cnt_d   = 6'd0;
                        work_d  = {33'd0, mag1};
                        dvsr_d  = mag2;
`ifdef HILO_DIV_SIGNED_EN
                        qneg_d  = neg1 ^ neg2;
                        rneg_d  = neg1;
`endif
                    end
                end
            end
            DivByZero: begin
                state_d  = DivEnd;
                result_d = 64'd0;
                ready_d  = 1'b1;
            end
            DivOn: begin
                if (annul_i) begin
                    state_d = DivFree;
                    cnt_d   = 6'd0;
                end else if (cnt_q != 6'd32) begin
                    if (!trial[32]) begin
                        work_d = {trial, work_q[30:0], 1'b1};
                    end else begin
                        work_d = {work_q[63:0], 1'b0};
                    end
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    state_d  = DivEnd;
                    cnt_d    = 6'd0;
                    result_d = {rem_fin, quo_fin};
                    ready_d  = 1'b1;
                end
            end
            default: begin
                // DivEnd: hold the result until the requester drops start_i
                if (!start_i) begin
                    state_d  = DivFree;
                    result_d = 64'd0;
                    ready_d  = 1'b0;
                end
            end
        endcase
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DivFree;
            cnt_q    <= 6'd0;
            work_q   <= 65'd0;
            dvsr_q   <= 32'd0;
            result_q <= 64'd0;
            ready_q  <= 1'b0;
`ifdef HILO_DIV_SIGNED_EN
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            dvsr_q   <= dvsr_d;
            result_q <= result_d;
            ready_q  <= ready_d;
`ifdef HILO_DIV_SIGNED_EN
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
`endif
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: doc/hilo_div.md
# hilo_div

Multi-cycle 32-bit radix-2 restoring divider serving as the responder for DIV/DIVU requests issued by the execute stage. The execute stage raises `start_i` with operands and holds its pipeline stalled. The divider iterates one quotient bit per cycle, then presents a 64-bit `{remainder, quotient}` result. The execute stage forwards that result as its HI/LO write request (HI = remainder, LO = quotient).

## Interface
- No parameters; operand width fixed at 32 bits, result width 64 bits.
- `clk`  in  1  — sole clock; all state updates on rising edge.
- `rst`  in  1  — synchronous, active-high reset (`RstEnable` = 1).
- `signed_div_i`  in  1  — 1: signed divide (DIV); 0: unsigned (DIVU).
- `opdata1_i`  in  32  — dividend; sampled only on the accepting edge.
- `opdata2_i`  in  32  — divisor; sampled only on the accepting edge.
- `start_i`  in  1  — request; held high by requester until result consumed.
- `annul_i`  in  1  — abort current request (flush from exception/branch).
- `result_o`  out  64  — `{remainder[31:0], quotient[31:0]}`; valid while `ready_o`=1, else 0.
- `ready_o`  out  1  — result valid (registered).

## Operation
- FSM states: DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END. Registers: state, 6-bit `cnt`, 65-bit working register `{rem[32:0], quo[31:0]}`, latched divisor magnitude, latched sign flags.
- DIV_FREE, `start_i`=1, `annul_i`=0:
  - divisor = 0 → DIV_BYZERO.
  - else → DIV_ON with `cnt`=0.
  - In signed mode, operand magnitudes are latched (two's-complement negate when bit 31 = 1).
  - Latched flags: `qneg` = sign1 XOR sign2; `rneg` = sign1.
- DIV_FREE with `start_i`=0, or `annul_i`=1 → stay.
- DIV_ON, `annul_i`=1 → DIV_FREE at the next edge; no result, `ready_o` stays 0.
- DIV_ON, `cnt` < 32, one iteration per edge:
  - Trial = `{rem[31:0], quo[31]}` − divisor, computed 33-bit.
  - If trial ≥ 0: rem ← trial, shift in quotient bit 1.
  - Else: rem ← `{rem[31:0], quo[31]}`, shift in quotient bit 0.
  - `cnt` += 1.
- DIV_ON, `cnt` = 32: apply sign fix, register `result_o` and `ready_o`=1, → DIV_END.
  - Sign fix negates the quotient if `qneg`, the remainder if `rneg`; signed mode only.
- DIV_BYZERO → DIV_END next edge; `result_o` = 0, `ready_o`=1.
- DIV_END: hold `result_o`/`ready_o` while `start_i`=1; `annul_i` ignored.
  - `start_i`=0 → DIV_FREE, `ready_o`=0, `result_o`=0.
- Arithmetic rules:
  - Magnitudes are unsigned 32-bit; |0x80000000| = 0x80000000.
  - Signed 0x80000000 / −1 yields quotient 0x80000000, remainder 0; no trap.
  - Remainder sign follows the dividend; |rem| < |divisor|.

## Timing
- Reset: state DIV_FREE, `cnt`=0, working register 0, `result_o`=0, `ready_o`=0.
  - Reset applies at the next edge regardless of state, including mid-iteration.
- Normal latency: request accepted at edge E0; `ready_o`=1 after edge E33. The result is visible 33 cycles after acceptance.
- Divide-by-zero latency: `ready_o`=1 after edge E1.
- `ready_o` stays high for at least one cycle. It falls on the edge after `start_i` is seen low in DIV_END.
- Back-to-back requests: `start_i` must drop for ≥1 edge between requests. DIV_END never re-accepts directly.
- Operand changes after E0 have no effect.
- `start_i` dropping while in DIV_ON is ignored; only `annul_i` or `rst` abort.

## Configuration
- `HILO_DIV_SIGNED_EN` defined:
  - `signed_div_i` is honored.
  - Magnitude conversion and the sign-fix step are built.
- Undefined:
  - The magnitude/sign logic is omitted; `signed_div_i` is ignored.
  - Every request is unsigned (DIVU semantics).
  - Latency and handshake are unchanged.

## Test plan
- Unsigned 100 / 7 → after 33 cycles `ready_o`=1, `result_o` = {0x00000002, 0x0000000E}. Hold `start_i` 5 extra cycles → result stable. Drop `start_i` → next edge `ready_o`=0, `result_o`=0.
- Signed −7 / 2 (0xFFFFFFF9 / 0x00000002) → `result_o` = {0xFFFFFFFF, 0xFFFFFFFD}. Signed 7 / −2 → {0x00000001, 0xFFFFFFFD}.
- Divisor 0 (dividend 0x12345678) → `ready_o`=1 after 2nd edge, `result_o` = 0.
- Start 0xFFFFFFFF / 3, assert `annul_i` at iteration 10 → DIV_FREE next edge, `ready_o` never rises. A following 9 / 3 request returns {0, 3} after 33 cycles.
- Signed 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}. With `HILO_DIV_SIGNED_EN` undefined, the same operands → {0x80000000, 0x00000000}.
- Assert `rst` at iteration 20 → next edge: DIV_FREE, outputs 0. A new request after `rst` release completes correctly.
